// File: rtl/fifo_ram_array.sv
// fifo_ram_array: DEPTH x DATA_LEN register array, one write port, one
// combinational read port. Contents are never reset.
// Ports:
//   clk          clock, rising edge
//   we           write enable
//   waddr/wdata  write address / payload
//   raddr        read address
//   rdata        mem[raddr], combinational
module fifo_ram_array #(
    parameter int unsigned DATA_LEN = 32,
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned AW       = 4
) (
    input  logic                clk,
    input  logic                we,
    input  logic [AW-1:0]       waddr,
    input  logic [DATA_LEN-1:0] wdata,
    input  logic [AW-1:0]       raddr,
    output logic [DATA_LEN-1:0] rdata
);

    logic [DATA_LEN-1:0] mem_q [DEPTH];

    // Storage write; no reset so the array maps onto plain flops or a regfile.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/fifo_hs_flush.sv
// fifo_hs_flush: synchronous FIFO with valid/ready handshakes on both sides,
// synchronous flush, occupancy count, almost-full/almost-empty thresholds and
// a sticky overflow/underflow error flag. Read side is first-word-fall-through.
// Ports:
//   clk, rstn            clock (rising edge), async active-low reset
//   flush                discard all entries next cycle
//   in_valid/in_ready    write handshake; in_ready = ~full
//   in_data              write payload
//   out_valid/out_ready  read handshake; out_valid = ~empty
//   out_data             head entry, FLUSH_DATA when empty
//   count                occupancy 0..DEPTH
//   full, empty          status
//   almost_full          count >= AFULL_TH
//   almost_empty         count <= AEMPTY_TH
//   err                  sticky overflow/underflow flag
//   err_clr              synchronous clear of err
module fifo_hs_flush #(
    parameter int unsigned                DATA_LEN   = 32,
    parameter int unsigned                ADDR_WIDTH = 4,
    parameter logic [DATA_LEN-1:0]        FLUSH_DATA = '0,
    parameter int                         AFULL_TH   = int'(2 ** ADDR_WIDTH) - 2,
    parameter int                         AEMPTY_TH  = 1
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_LEN-1:0]   in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_LEN-1:0]   out_data,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  err,
    input  logic                  err_clr
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
    localparam int unsigned PW    = ADDR_WIDTH + 1;
    // Array address width; a depth-1 FIFO still needs a 1-bit address port.
    localparam int unsigned AW    = (ADDR_WIDTH > 0) ? ADDR_WIDTH : 1;
    localparam logic [AW-1:0] ADDR_MASK = AW'(DEPTH - 1);

    logic [PW-1:0]       wptr_q, wptr_d;
    logic [PW-1:0]       rptr_q, rptr_d;
    logic                err_q,  err_d;

    logic                push_c, pop_c;
    logic                ovf_c,  unf_c;
    logic [AW-1:0]       waddr_c, raddr_c;
    logic [DATA_LEN-1:0] rdata_c;

    // Low address bits of each pointer; the MSB is the wrap bit.
    assign waddr_c = AW'(wptr_q) & ADDR_MASK;
    assign raddr_c = AW'(rptr_q) & ADDR_MASK;

    // Status derived purely from the pointer flops.
    assign empty        = (wptr_q == rptr_q);
    assign full         = (wptr_q[PW-1] != rptr_q[PW-1]) && (waddr_c == raddr_c);
    assign count        = wptr_q - rptr_q;
    assign in_ready     = ~full;
    assign out_valid    = ~empty;
    assign almost_full  = (int'(count) >= AFULL_TH);
    assign almost_empty = (int'(count) <= AEMPTY_TH);
    assign err          = err_q;
    assign out_data     = empty ? FLUSH_DATA : rdata_c;

    assign push_c = in_valid & in_ready & ~flush;
    assign pop_c  = out_valid & out_ready & ~flush;

    // A push offered while full is not flagged when a pop drains the FIFO in
    // the same cycle; the producer simply retries once in_ready rises.
    assign ovf_c  = in_valid & full & ~out_ready & ~flush;
    assign unf_c  = out_ready & empty & ~flush;

    // Next-state for pointers and error flag.
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        err_d  = err_q;
        if (flush) begin
            wptr_d = '0;
            rptr_d = '0;
        end else begin
            if (push_c) begin
                wptr_d = wptr_q + PW'(1);
            end
            if (pop_c) begin
                rptr_d = rptr_q + PW'(1);
            end
        end
        // Set has priority over clear; flush leaves err untouched.
        if (err_clr) begin
            err_d = 1'b0;
        end
        if (ovf_c || unf_c) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr_q <= '0;
            rptr_q <= '0;
            err_q  <= 1'b0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            err_q  <= err_d;
        end
    end

    fifo_ram_array #(
        .DATA_LEN (DATA_LEN),
        .DEPTH    (DEPTH),
        .AW       (AW)
    ) u_ram (
        .clk   (clk),
        .we    (push_c),
        .waddr (waddr_c),
        .wdata (in_data),
        .raddr (raddr_c),
        .rdata (rdata_c)
    );

endmodule

// File: tb/tb_fifo_hs_flush.sv
// Testbench for fifo_hs_flush (DEPTH=4): directed scenarios plus randomized
// traffic, all compared against a queue-based reference model.
module tb_fifo_hs_flush;

    localparam int          DW    = 32;
    localparam int          AW    = 2;
    localparam int          DEPTH = 4;
    localparam logic [31:0] FD    = 32'hF1F0_0000;

    logic          clk;
    logic          rstn;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [AW:0]   count;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          almost_empty;
    logic          err;
    logic          err_clr;

    fifo_hs_flush #(
        .DATA_LEN   (DW),
        .ADDR_WIDTH (AW),
        .FLUSH_DATA (FD)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .count        (count),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .err          (err),
        .err_clr      (err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: contents as a queue plus the sticky error bit.
    logic [31:0] model_q[$];
    logic        err_m;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic check_state(input string ph);
        int          n;
        logic [31:0] head;
        n    = model_q.size();
        head = (n == 0) ? FD : model_q[0];
        chk({ph, ":count"},     32'(count),        32'(n));
        chk({ph, ":full"},      32'(full),         32'(n == DEPTH));
        chk({ph, ":empty"},     32'(empty),        32'(n == 0));
        chk({ph, ":in_ready"},  32'(in_ready),     32'(n != DEPTH));
        chk({ph, ":out_valid"}, 32'(out_valid),    32'(n != 0));
        chk({ph, ":out_data"},  out_data,          head);
        chk({ph, ":afull"},     32'(almost_full),  32'(n >= DEPTH - 2));
        chk({ph, ":aempty"},    32'(almost_empty), 32'(n <= 1));
        chk({ph, ":err"},       32'(err),          32'(err_m));
    endtask

    // One clock: apply inputs, check current state, advance model, clock.
    task automatic cycle(input string ph, input logic iv, input logic [31:0] d,
                         input logic ordy, input logic fl, input logic ec);
        int   n;
        logic set;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        err_clr   = ec;
        #1;
        check_state(ph);
        n   = model_q.size();
        set = 1'b0;
        if (fl) begin
            model_q.delete();
        end else begin
            if ((iv && n == DEPTH && !ordy) || (ordy && n == 0)) set = 1'b1;
            if (ordy && n != 0) void'(model_q.pop_front());
            if (iv && n != DEPTH) model_q.push_back(d);
        end
        if (set) err_m = 1'b1;
        else if (ec) err_m = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input string ph);
        cycle(ph, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rstn = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0;
        out_ready = 1'b0; err_clr = 1'b0;
        err_m = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_state("t1_in_reset");
        rstn = 1'b1;
        @(posedge clk);
        #1;
        idle("t1_after_reset");

        // Fill then drain in order.
        for (int i = 0; i < DEPTH; i++) cycle("t2_fill", 1'b1, 32'hA0 + 32'(i), 1'b0, 1'b0, 1'b0);
        chk("t2_full_const", 32'(full), 32'd1);
        chk("t2_count_const", 32'(count), 32'd4);
        for (int i = 0; i < DEPTH; i++) begin
            chk("t2_drain_order", out_data, 32'hA0 + 32'(i));
            cycle("t2_drain", 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        end
        chk("t2_empty_const", 32'(empty), 32'd1);

        // Full with push+pop offered together: pop wins, push refused.
        for (int i = 0; i < DEPTH; i++) cycle("t3_fill", 1'b1, 32'hA0 + 32'(i), 1'b0, 1'b0, 1'b0);
        cycle("t3_both", 1'b1, 32'hB0, 1'b1, 1'b0, 1'b0);
        chk("t3_count_const", 32'(count), 32'd3);
        chk("t3_in_ready_const", 32'(in_ready), 32'd1);
        chk("t3_err_const", 32'(err), 32'd0);
        chk("t3_head_const", out_data, 32'hA1);

        // Flush with push+pop in the flush cycle.
        cycle("t4_flush", 1'b1, 32'h77, 1'b1, 1'b1, 1'b0);
        chk("t4_empty_const", 32'(empty), 32'd1);
        chk("t4_data_const", out_data, FD);
        cycle("t4_push55", 1'b1, 32'h55, 1'b0, 1'b0, 1'b0);
        chk("t4_readback_const", out_data, 32'h55);
        cycle("t4_pop55", 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

        // Error flag: overflow, survives flush, clear, underflow, set-beats-clear.
        for (int i = 0; i < DEPTH; i++) cycle("t5_fill", 1'b1, 32'hC0 + 32'(i), 1'b0, 1'b0, 1'b0);
        cycle("t5_ovf", 1'b1, 32'hCC, 1'b0, 1'b0, 1'b0);
        chk("t5_err_set_const", 32'(err), 32'd1);
        cycle("t5_flush", 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        chk("t5_err_sticky_const", 32'(err), 32'd1);
        cycle("t5_clr", 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        chk("t5_err_clr_const", 32'(err), 32'd0);
        cycle("t5_unf", 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        chk("t5_err_unf_const", 32'(err), 32'd1);
        cycle("t5_set_vs_clr", 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
        chk("t5_set_wins_const", 32'(err), 32'd1);
        cycle("t5_clr2", 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);

        // Randomized traffic with wrap-around, occasional flush and err_clr.
        for (int i = 0; i < 400; i++) begin
            cycle("t6_rand", ($urandom_range(0, 99) < 60), $urandom,
                  ($urandom_range(0, 99) < 50), ($urandom_range(0, 31) == 0),
                  ($urandom_range(0, 7) == 0));
        end

        // Async reset mid-operation.
        cycle("t7_push", 1'b1, 32'hD0, 1'b0, 1'b0, 1'b0);
        cycle("t7_push", 1'b1, 32'hD1, 1'b0, 1'b0, 1'b0);
        cycle("t7_unf_prep", 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        cycle("t7_unf", 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        cycle("t7_push", 1'b1, 32'hD2, 1'b0, 1'b0, 1'b0);
        in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0; err_clr = 1'b0;
        rstn = 1'b0;
        #1;
        model_q.delete();
        err_m = 1'b0;
        check_state("t7_async_rst");
        @(posedge clk);
        #1;
        rstn = 1'b1;
        idle("t7_after_rst");
        cycle("t7_repush", 1'b1, 32'hE0, 1'b0, 1'b0, 1'b0);
        idle("t7_readback");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
